// File: rtl/lane_serializer.sv
// Parallel-to-serial lane transmitter: takes one P-lane word per handshake and
// emits the kept lanes lowest-index first over a W-bit valid/ready stream.

module lane_ser_cell #(
   parameter int W = 8
) (
   input  logic         mask_i,
   input  logic         below_i,
   input  logic [W-1:0] lane_i,
   output logic         below_o,
   output logic         sel_o,
   output logic [W-1:0] data_o
);
   // A lane is selected when it is pending and no lower lane is pending.
   assign sel_o   = mask_i & ~below_i;
   assign below_o = below_i | mask_i;
   assign data_o  = sel_o ? lane_i : '0;
endmodule

module lane_serializer #(
   parameter int P  = 4,
   parameter int W  = 8,
   parameter int CW = (P > 1) ? $clog2(P) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [P*W-1:0]  in_data,
   input  logic [P-1:0]    in_keep,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    out_data,
   output logic [CW-1:0]   out_lane,
   output logic            out_last
);
   typedef enum logic {IDLE, SEND} state_e;

   state_e             state_q, state_d;
   logic [P*W-1:0]     buf_q, buf_d;
   logic [P-1:0]       mask_q, mask_d;
   logic               out_valid_q, out_valid_d;
   logic [W-1:0]       out_data_q, out_data_d;
   logic [CW-1:0]      out_lane_q, out_lane_d;
   logic               out_last_q, out_last_d;

   logic               accept, beat;
   logic [P:0]         below;
   logic [P-1:0]       sel;
   logic [P-1:0][W-1:0] lane_dat;

   assign beat     = out_valid_q && out_ready;
   assign in_ready = rst_n && ((state_q == IDLE) || (beat && out_last_q));
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      mask_d  = mask_q;
      if (beat) begin
         // Clearing the lowest set bit retires the lane just sent.
         mask_d = mask_q & (mask_q - P'(1));
         if (out_last_q) state_d = IDLE;
      end
      if (accept) begin
         buf_d   = in_data;
         mask_d  = in_keep;
         state_d = (|in_keep) ? SEND : IDLE;
      end
   end

   // Lane picker runs on next-state mask/buffer so the outputs can be registered.
   assign below[0] = 1'b0;
   for (genvar g = 0; g < P; g++) begin : g_lane
      lane_ser_cell #(.W(W)) u_cell (
         .mask_i  (mask_d[g]),
         .below_i (below[g]),
         .lane_i  (buf_d[g*W +: W]),
         .below_o (below[g+1]),
         .sel_o   (sel[g]),
         .data_o  (lane_dat[g])
      );
   end

   always_comb begin
      out_data_d = '0;
      out_lane_d = '0;
      for (int i = 0; i < P; i++) begin
         out_data_d = out_data_d | lane_dat[i];
         if (sel[i]) out_lane_d = CW'(i);
      end
      out_valid_d = (state_d == SEND);
      out_last_d  = below[P] && ((mask_d & (mask_d - P'(1))) == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         buf_q       <= '0;
         mask_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_lane_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         mask_q      <= mask_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_lane_q  <= out_lane_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_lane  = out_lane_q;
   assign out_last  = out_last_q;
endmodule

// File: tb/tb_lane_serializer.sv
// Directed bench for lane_serializer at P=4, W=8 with hand-computed beats.

module tb_lane_serializer;
   localparam int P  = 4;
   localparam int W  = 8;
   localparam int CW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [P*W-1:0]  in_data;
   logic [P-1:0]    in_keep;
   logic            out_valid;
   logic            out_ready;
   logic [W-1:0]    out_data;
   logic [CW-1:0]   out_lane;
   logic            out_last;

   int n_cmp = 0;
   int n_err = 0;

   lane_serializer #(.P(P), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_keep   (in_keep),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_lane  (out_lane),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic beat_chk(input string tag, input logic [7:0] d, input logic [1:0] ln,
                           input logic lst);
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".data"},  32'(out_data),  32'(d));
      chk({tag, ".lane"},  32'(out_lane),  32'(ln));
      chk({tag, ".last"},  32'(out_last),  32'(lst));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h44332211;
      in_keep   = 4'hF;
      out_ready = 1'b1;

      // reset held with a word offered
      tick(); tick();
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.in_ready",  32'(in_ready),  32'd0);
      chk("rst.out_data",  32'(out_data),  32'h0);
      chk("rst.out_lane",  32'(out_lane),  32'h0);
      chk("rst.out_last",  32'(out_last),  32'h0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      #1;
      chk("rel.in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("rel.in_ready2",  32'(in_ready),  32'd1);
      chk("rel.out_valid",  32'(out_valid), 32'd0);
      tick();
      chk("rel.out_valid2", 32'(out_valid), 32'd0);

      // full word
      in_valid = 1'b1; in_data = 32'h44332211; in_keep = 4'hF;
      #1 chk("full.in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0; in_data = 32'hFFFFFFFF; in_keep = 4'h0;
      beat_chk("full.b0", 8'h11, 2'd0, 1'b0);
      chk("full.busy", 32'(in_ready), 32'd0);
      tick(); beat_chk("full.b1", 8'h22, 2'd1, 1'b0);
      tick(); beat_chk("full.b2", 8'h33, 2'd2, 1'b0);
      tick(); beat_chk("full.b3", 8'h44, 2'd3, 1'b1);
      chk("full.last_rdy", 32'(in_ready), 32'd1);
      tick();
      chk("full.done", 32'(out_valid), 32'd0);

      // sparse keep
      in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_keep = 4'b1010;
      tick();
      in_valid = 1'b0;
      beat_chk("sparse.b0", 8'hBB, 2'd1, 1'b0);
      tick(); beat_chk("sparse.b1", 8'hDD, 2'd3, 1'b1);
      chk("sparse.rdy", 32'(in_ready), 32'd1);
      tick();
      chk("sparse.done", 32'(out_valid), 32'd0);

      // backpressure on lane 1
      in_valid = 1'b1; in_data = 32'h44332211; in_keep = 4'hF;
      tick();
      in_valid = 1'b0;
      beat_chk("bp.b0", 8'h11, 2'd0, 1'b0);
      tick();
      beat_chk("bp.b1", 8'h22, 2'd1, 1'b0);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         beat_chk($sformatf("bp.hold%0d", i), 8'h22, 2'd1, 1'b0);
         chk($sformatf("bp.rdy%0d", i), 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick(); beat_chk("bp.b2", 8'h33, 2'd2, 1'b0);
      tick(); beat_chk("bp.b3", 8'h44, 2'd3, 1'b1);
      tick();
      chk("bp.done", 32'(out_valid), 32'd0);

      // back-to-back words, no bubble
      in_valid = 1'b1; in_data = 32'h44332211; in_keep = 4'hF;
      tick();
      in_data = 32'h88776655;
      beat_chk("b2b.b0", 8'h11, 2'd0, 1'b0);
      tick(); beat_chk("b2b.b1", 8'h22, 2'd1, 1'b0);
      tick(); beat_chk("b2b.b2", 8'h33, 2'd2, 1'b0);
      tick(); beat_chk("b2b.b3", 8'h44, 2'd3, 1'b1);
      chk("b2b.accept", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      beat_chk("b2b.b4", 8'h55, 2'd0, 1'b0);
      tick(); beat_chk("b2b.b5", 8'h66, 2'd1, 1'b0);
      tick(); beat_chk("b2b.b6", 8'h77, 2'd2, 1'b0);
      tick(); beat_chk("b2b.b7", 8'h88, 2'd3, 1'b1);
      tick();
      chk("b2b.done", 32'(out_valid), 32'd0);

      // empty word
      in_valid = 1'b1; in_data = 32'h12345678; in_keep = 4'h0;
      #1 chk("empty.rdy", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("empty.valid", 32'(out_valid), 32'd0);
      chk("empty.rdy2",  32'(in_ready),  32'd1);
      tick();
      chk("empty.valid2", 32'(out_valid), 32'd0);

      // reset mid-word while lane 2 is presented
      in_valid = 1'b1; in_data = 32'h44332211; in_keep = 4'hF;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      beat_chk("mid.b2", 8'h33, 2'd2, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid.valid", 32'(out_valid), 32'd0);
      chk("mid.rdy",   32'(in_ready),  32'd0);
      chk("mid.data",  32'(out_data),  32'h0);
      tick();
      rst_n = 1'b1;
      #1 chk("mid.rel_rdy", 32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("mid.quiet%0d", i), 32'(out_valid), 32'd0);
      end
      chk("mid.rdy_end", 32'(in_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
